mdio_slave: RTL and testbench

- Clause-22 MDIO management responder: the PHY-side end of an MDC/MDIO link, driven by an external station manager.
- Samples MDC/MDIO in the 125 MHz system domain and decodes read and write frames addressed to PHY_ADDRESS.
- Serves a 32x16 register file and reports accepted writes to fabric logic.
- Used as an FPGA-resident management target and as the bench responder for the MDIO master.

---
 rtl/mdio_pkg.sv | 34 +++
 rtl/mdio_edge_sync.sv | 42 ++++
 rtl/mdio_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder.
// Holds the opcode encodings, frame field widths, the responder state
// encoding and the read-only register indices, plus a helper that tells
// whether a register address is write-protected.
package mdio_pkg;

   localparam logic [1:0] MDIO_OP_READ  = 2'b10;
   localparam logic [1:0] MDIO_OP_WRITE = 2'b01;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;

   localparam logic [REGAD_W-1:0] REG_STATUS  = 5'd1;
   localparam logic [REGAD_W-1:0] REG_PHY_ID1 = 5'd2;
   localparam logic [REGAD_W-1:0] REG_PHY_ID2 = 5'd3;

   typedef enum logic [3:0] {
      IDLE,
      START,
      OPCODE,
      PHYAD,
      REGAD,
      TURNAROUND,
      READ_DATA,
      WRITE_DATA,
      SKIP
   } mdio_slave_state_t;

   function automatic logic is_read_only(input logic [REGAD_W-1:0] addr);
      return (addr == REG_STATUS) || (addr == REG_PHY_ID1) || (addr == REG_PHY_ID2);
   endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the clk domain and produces one-clk pulses on
// the synchronized MDC edges.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   mdc, mdio_i  asynchronous inputs from the MDIO bus
//   mdio_s       synchronized MDIO, aligned with the rise/fall pulses
//   rise, fall   one-clk pulses on synchronized MDC rising/falling edges
module mdio_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic mdc,
   input  logic mdio_i,
   output logic mdio_s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] mdc_ff;
   logic [SYNC_STAGES-1:0] mdio_ff;
   logic                   mdc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         mdc_ff  <= '0;
         mdio_ff <= '1;
         mdc_d   <= 1'b0;
      end else begin
         mdc_ff  <= {mdc_ff[SYNC_STAGES-2:0], mdc};
         mdio_ff <= {mdio_ff[SYNC_STAGES-2:0], mdio_i};
         mdc_d   <= mdc_ff[SYNC_STAGES-1];
      end
   end

   // Both chains have equal depth, so mdio_s shows the bus value that was
   // present when the detected MDC edge happened.
   assign mdio_s = mdio_ff[SYNC_STAGES-1];
   assign rise   =  mdc_ff[SYNC_STAGES-1] & ~mdc_d;
   assign fall   = ~mdc_ff[SYNC_STAGES-1] &  mdc_d;

endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO management responder (PHY side).
// Decodes read/write frames addressed to PHY_ADDRESS, serves a 32x16
// register file (reg1 = live status, reg2/3 = PHY ID) and reports
// accepted writes to fabric logic.
// Ports:
//   clk, reset     125 MHz system clock, synchronous active-high reset
//   mdc, mdio_i    management clock and MDIO pad input (async to clk)
//   mdio_o, mdio_t MDIO pad output value and tristate (1 = Hi-Z)
//   status_reg     live value returned for register 1
//   wr_valid       one-clk pulse per accepted write
//   wr_addr/data   register address and data of the accepted write
module mdio_slave
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDRESS   = 5'h0c,
   parameter int                 PREAMBLE_BITS = 32,
   parameter int                 SYNC_STAGES   = 2,
   parameter logic [DATA_W-1:0]  PHY_ID1       = 16'h2000,
   parameter logic [DATA_W-1:0]  PHY_ID2       = 16'h5c90
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mdc,
   input  logic               mdio_i,
   output logic               mdio_o,
   output logic               mdio_t,
   input  logic [DATA_W-1:0]  status_reg,
   output logic               wr_valid,
   output logic [REGAD_W-1:0] wr_addr,
   output logic [DATA_W-1:0]  wr_data
);

   localparam int                PRE_W   = $clog2(PREAMBLE_BITS + 1);
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PREAMBLE_BITS);
   // Bits left after OPCODE in a 32-bit frame: PHYAD, REGAD, TA, DATA.
   localparam logic [4:0]        SKIP_OP_BITS = 5'(PHYAD_W + REGAD_W + 2 + DATA_W - 1);
   localparam logic [4:0]        SKIP_TA_BITS = 5'(DATA_W - 1);

   mdio_slave_state_t state, state_nxt;

   logic                mdio_s, rise, fall;
   logic [PRE_W-1:0]    pre_cnt;
   logic [4:0]          bit_cnt;
   logic                op_msb, ta_msb;
   logic                is_read, drop;
   logic [PHYAD_W-2:0]  phy_sh;
   logic [REGAD_W-2:0]  reg_sh;
   logic [REGAD_W-1:0]  reg_addr;
   logic [DATA_W-1:0]   rd_sh;
   logic [DATA_W-2:0]   wr_sh;
   logic [DATA_W-1:0]   regs [32];

   logic [1:0]          op_word;
   logic                op_ok;
   logic [PHYAD_W-1:0]  phyad_full;
   logic [REGAD_W-1:0]  regad_full;
   logic [DATA_W-1:0]   wdata_full;
   logic                ta_bad;
   logic [DATA_W-1:0]   rd_word;

   mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .mdc    (mdc),
      .mdio_i (mdio_i),
      .mdio_s (mdio_s),
      .rise   (rise),
      .fall   (fall)
   );

   // Each field is completed by the bit being sampled on the current rise.
   assign op_word    = {op_msb, mdio_s};
   assign op_ok      = (op_word == MDIO_OP_READ) || (op_word == MDIO_OP_WRITE);
   assign phyad_full = {phy_sh, mdio_s};
   assign regad_full = {reg_sh, mdio_s};
   assign wdata_full = {wr_sh, mdio_s};
   // Only writes have a master-driven turnaround to validate.
   assign ta_bad     = !is_read && ({ta_msb, mdio_s} != 2'b10);

   always_comb begin
      case (regad_full)
         REG_STATUS:  rd_word = status_reg;
         REG_PHY_ID1: rd_word = PHY_ID1;
         REG_PHY_ID2: rd_word = PHY_ID2;
         default:     rd_word = regs[regad_full];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rise) begin
         case (state)
            IDLE:       if (!mdio_s && pre_cnt == PRE_MAX) state_nxt = START;
            START:      state_nxt = mdio_s ? OPCODE : IDLE;
            OPCODE:     if (bit_cnt == 5'd0) state_nxt = op_ok ? PHYAD : SKIP;
            PHYAD:      if (bit_cnt == 5'd0) state_nxt = REGAD;
            REGAD:      if (bit_cnt == 5'd0) state_nxt = TURNAROUND;
            TURNAROUND: if (bit_cnt == 5'd0)
                           state_nxt = (drop || ta_bad) ? SKIP :
                                       (is_read ? READ_DATA : WRITE_DATA);
            WRITE_DATA: if (bit_cnt == 5'd0) state_nxt = IDLE;
            SKIP:       if (bit_cnt == 5'd0) state_nxt = IDLE;
            READ_DATA:  state_nxt = READ_DATA;
            default:    state_nxt = IDLE;
         endcase
      end else if (fall && state == READ_DATA && bit_cnt == 5'(DATA_W)) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt  <= '0;
         bit_cnt  <= '0;
         op_msb   <= 1'b0;
         ta_msb   <= 1'b0;
         is_read  <= 1'b0;
         drop     <= 1'b0;
         phy_sh   <= '0;
         reg_sh   <= '0;
         reg_addr <= '0;
         rd_sh    <= '0;
         wr_sh    <= '0;
         mdio_o   <= 1'b0;
         mdio_t   <= 1'b1;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         wr_valid <= 1'b0;
         // Leaving IDLE forgets the preamble, so every frame needs a full one.
         if (state != IDLE) pre_cnt <= '0;
         if (rise) begin
            case (state)
               IDLE: begin
                  if (!mdio_s)                pre_cnt <= '0;
                  else if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + PRE_W'(1);
               end
               START: bit_cnt <= 5'd1;
               OPCODE: begin
                  op_msb <= mdio_s;
                  if (bit_cnt == 5'd0) begin
                     is_read <= (op_word == MDIO_OP_READ);
                     drop    <= 1'b0;
                     bit_cnt <= op_ok ? 5'(PHYAD_W - 1) : SKIP_OP_BITS;
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end
               PHYAD: begin
                  phy_sh <= phyad_full[PHYAD_W-2:0];
                  if (bit_cnt == 5'd0) begin
                     drop    <= (phyad_full != PHY_ADDRESS);
                     bit_cnt <= 5'(REGAD_W - 1);
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end
               REGAD: begin
                  reg_sh <= regad_full[REGAD_W-2:0];
                  if (bit_cnt == 5'd0) begin
                     reg_addr <= regad_full;
                     // Snapshot now; status_reg may move during TA/data.
                     if (is_read && !drop) rd_sh <= rd_word;
                     bit_cnt <= 5'd1;
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end
               TURNAROUND: begin
                  ta_msb <= mdio_s;
                  if (bit_cnt == 5'd0)
                     bit_cnt <= (is_read && !drop) ? 5'd0 : SKIP_TA_BITS;
                  else
                     bit_cnt <= bit_cnt - 5'd1;
               end
               WRITE_DATA: begin
                  wr_sh <= wdata_full[DATA_W-2:0];
                  if (bit_cnt == 5'd0) begin
                     if (!is_read_only(reg_addr)) begin
                        regs[reg_addr] <= wdata_full;
                        wr_valid       <= 1'b1;
                        wr_addr        <= reg_addr;
                        wr_data        <= wdata_full;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
               end
               SKIP: if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 5'd1;
               default: ;
            endcase
         end else if (fall) begin
            case (state)
               TURNAROUND: begin
                  // Second TA bit: take the bus and hold it low.
                  if (bit_cnt == 5'd0 && is_read && !drop) begin
                     mdio_o <= 1'b0;
                     mdio_t <= 1'b0;
                  end
               end
               READ_DATA: begin
                  if (bit_cnt != 5'(DATA_W)) begin
                     mdio_o  <= rd_sh[DATA_W-1];
                     rd_sh   <= {rd_sh[DATA_W-2:0], 1'b0};
                     bit_cnt <= bit_cnt + 5'd1;
                  end else begin
                     mdio_o <= 1'b0;
                     mdio_t <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: a station-manager model bit-bangs
// MDC/MDIO frames from a vector table; expected read data and write strobes
// are queued when a frame is issued and consumed when the DUT answers.
module tb_mdio_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mdc = 1'b0;
   logic        m_oe = 1'b1;
   logic        m_val = 1'b1;
   logic        mdio_o, mdio_t, wr_valid;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic [15:0] status_reg = 16'h0000;
   wire         mdio_i;

   // Open-drain style bus with pull-up: DUT wins when it drives.
   assign mdio_i = mdio_t ? (m_oe ? m_val : 1'b1) : mdio_o;

   always #4 clk = ~clk;

   mdio_slave dut (
      .clk        (clk),
      .reset      (reset),
      .mdc        (mdc),
      .mdio_i     (mdio_i),
      .mdio_o     (mdio_o),
      .mdio_t     (mdio_t),
      .status_reg (status_reg),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   typedef struct {
      logic        is_rd;
      logic [4:0]  phy;
      logic [4:0]  reg_a;
      logic [15:0] wdata;
      logic [1:0]  ta;
      int          pre;
      logic [15:0] st_pre;
      logic [15:0] st_post;
      logic        exp_resp;
      logic [15:0] exp_data;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [15:0] d;
   } wr_t;

   vec_t        vecs[14];
   wr_t         exp_q[$];
   logic [15:0] rd_q[$];
   int          nchk = 0;
   int          nfail = 0;
   int          tlow = 0;
   int          cur_vec = -1;
   logic        prev_wr = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, cur_vec, act, exp);
      end
   endtask

   // One clk of observation: counts driven cycles and scores write strobes.
   task automatic tick();
      wr_t w;
      @(negedge clk);
      if (!mdio_t) tlow++;
      if (wr_valid) begin
         chk("wr_pulse_width", 32'(prev_wr), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_wr_valid", 32'(wr_valid), 32'd0);
         end else begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(w.a));
            chk("wr_data", 32'(wr_data), 32'(w.d));
         end
      end
      prev_wr = wr_valid;
   endtask

   // One MDC period: master changes MDIO with MDC low, samples before rise.
   task automatic bit_cycle(input logic oe, input logic val, output logic s, output logic tz);
      tick();
      mdc = 1'b0; m_oe = oe; m_val = val;
      repeat (8) tick();
      s = mdio_i; tz = mdio_t;
      mdc = 1'b1;
      repeat (7) tick();
   endtask

   task automatic send_bits(input logic [15:0] val, input int n);
      logic s, tz;
      for (int i = n - 1; i >= 0; i--) bit_cycle(1'b1, val[i], s, tz);
   endtask

   task automatic run_frame(input vec_t v, input int rst_at);
      logic        s, tz, ta1_tz, ta2_s;
      logic [15:0] rd;
      logic [15:0] e;
      int          t0;
      wr_t         w;
      status_reg = v.st_pre;
      t0 = tlow;
      if (v.is_rd && v.exp_resp) rd_q.push_back(v.exp_data);
      if (!v.is_rd && v.exp_resp) begin
         w.a = v.reg_a; w.d = v.exp_data;
         exp_q.push_back(w);
      end
      for (int i = 0; i < v.pre; i++) bit_cycle(1'b1, 1'b1, s, tz);
      send_bits(16'b01, 2);
      send_bits(v.is_rd ? 16'b10 : 16'b01, 2);
      send_bits(16'(v.phy), 5);
      send_bits(16'(v.reg_a), 5);
      status_reg = v.st_post;
      if (v.is_rd) begin
         bit_cycle(1'b0, 1'b0, s, ta1_tz);
         bit_cycle(1'b0, 1'b0, ta2_s, tz);
         rd = '0;
         for (int i = 0; i < 16; i++) begin
            bit_cycle(1'b0, 1'b0, s, tz);
            rd = {rd[14:0], s};
            if (i == rst_at) begin
               chk("drive_before_reset", 32'(mdio_t), 32'd0);
               @(negedge clk);
               reset = 1'b1;
               @(negedge clk);
               chk("reset_releases_bus", 32'(mdio_t), 32'd1);
               reset = 1'b0;
               if (rd_q.size() != 0) void'(rd_q.pop_front());
               return;
            end
         end
         // Trailing 0 both lets the release fall happen and breaks any run
         // of 1s, so the next frame's preamble length is exactly its own.
         bit_cycle(1'b1, 1'b0, s, tz);
         if (v.exp_resp) begin
            chk("ta1_hiz", 32'(ta1_tz), 32'd1);
            chk("ta2_zero", 32'(ta2_s), 32'd0);
            chk("drive_clks_17_periods", 32'(tlow - t0), 32'd272);
            e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
            chk("read_data", 32'(rd), 32'(e));
         end else begin
            chk("no_drive_clks", 32'(tlow - t0), 32'd0);
         end
      end else begin
         send_bits(16'(v.ta), 2);
         send_bits(v.wdata, 16);
         bit_cycle(1'b1, 1'b0, s, tz);
         chk("wr_missing", 32'(exp_q.size()), 32'd0);
         chk("write_no_drive", 32'(tlow - t0), 32'd0);
      end
   endtask

   initial begin
      vec_t v;
      logic s, tz;
      //          rd    phy    reg    wdata     ta     pre st_pre    st_post   resp  exp
      vecs[0]  = '{1'b1, 5'h0c, 5'd2, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h2000};
      vecs[1]  = '{1'b0, 5'h0c, 5'd0, 16'h1140, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h1140};
      vecs[2]  = '{1'b1, 5'h0c, 5'd0, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h1140};
      vecs[3]  = '{1'b1, 5'h0d, 5'd0, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[4]  = '{1'b0, 5'h0d, 5'd0, 16'hbeef, 2'b10, 32, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[5]  = '{1'b1, 5'h0c, 5'd0, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h1140};
      vecs[6]  = '{1'b1, 5'h0c, 5'd2, 16'h0000, 2'b10, 31, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[7]  = '{1'b0, 5'h0c, 5'd3, 16'hffff, 2'b10, 32, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[8]  = '{1'b1, 5'h0c, 5'd3, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h5c90};
      vecs[9]  = '{1'b0, 5'h0c, 5'd0, 16'h0bad, 2'b11, 32, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[10] = '{1'b1, 5'h0c, 5'd0, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'h1140};
      vecs[11] = '{1'b0, 5'h0c, 5'd7, 16'ha5c3, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'ha5c3};
      vecs[12] = '{1'b1, 5'h0c, 5'd7, 16'h0000, 2'b10, 32, 16'h1234, 16'h1234, 1'b1, 16'ha5c3};
      vecs[13] = '{1'b1, 5'h0c, 5'd1, 16'h0000, 2'b10, 32, 16'h796d, 16'h0000, 1'b1, 16'h796d};

      reset = 1'b1;
      repeat (5) tick();
      chk("reset_mdio_t", 32'(mdio_t), 32'd1);
      chk("reset_mdio_o", 32'(mdio_o), 32'd0);
      chk("reset_wr_valid", 32'(wr_valid), 32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_wr_data", 32'(wr_data), 32'd0);
      reset = 1'b0;
      repeat (4) bit_cycle(1'b1, 1'b1, s, tz);

      foreach (vecs[i]) begin
         cur_vec = i;
         run_frame(vecs[i], -1);
      end

      // Reset while the DUT is shifting out data bit 5 of a reg2 read.
      cur_vec = 100;
      v = vecs[0];
      run_frame(v, 5);
      repeat (4) bit_cycle(1'b1, 1'b1, s, tz);
      bit_cycle(1'b1, 1'b0, s, tz);
      cur_vec = 101;
      run_frame(v, -1);
      // Reset cleared the file, so reg 0 reads back zero again.
      cur_vec = 102;
      v = vecs[2];
      v.exp_data = 16'h0000;
      run_frame(v, -1);

      cur_vec = -1;
      chk("scoreboard_empty", 32'(exp_q.size() + rd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
